seq_divider32: RTL and testbench
================================

SEQ_DIVIDER32 -- requirements
Module: seq_divider32

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; iteration count equals WIDTH.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while idle.
REQ-005 is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 dividend  input  WIDTH  numerator; sampled with start.
REQ-007 divisor  input  WIDTH  denominator; sampled with start.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 quotient  output  WIDTH  result; held until next done.
REQ-011 remainder  output  WIDTH  result; held until next done.
REQ-012 div_by_zero  output  1  flag for the last completed operation; held until next done.

Function
REQ-013 Algorithm SHALL be restoring shift-subtract, one quotient bit per cycle, MSB first: the inverse of the team's shift-add multiplier.
REQ-014 States SHALL be IDLE, RUN, FINISH; IDLE -> RUN on start; RUN -> FINISH after WIDTH iterations; FINISH -> IDLE unconditionally.
REQ-015 At the accept edge (IDLE, start=1), the block SHALL latch operand magnitudes (absolute values when is_signed), the result signs, the zero-divisor flag and clear the iteration counter and partial remainder.
REQ-016 Each RUN edge SHALL shift {rem,quo} left one bit and, if shifted rem >= divisor magnitude, subtract it and set quo LSB to 1.
REQ-017 FINISH edge SHALL apply sign correction, write quotient/remainder/div_by_zero and assert done for exactly the following cycle.
REQ-018 Latency SHALL be fixed: done high in the cycle after the (WIDTH+1)th edge following the accept edge (33 edges at WIDTH=32), independent of operand values.
REQ-019 busy SHALL be high from the cycle after the accept edge through RUN and FINISH, and SHALL be low in the done cycle.
REQ-020 start while busy SHALL be ignored; start in the done cycle SHALL be accepted (back-to-back operation).
REQ-021 Signed mode: quotient truncates toward zero; remainder takes the dividend's sign; quotient negative iff operand signs differ and divisor nonzero.
REQ-022 Signed most-negative / -1 SHALL yield quotient = most-negative value (wrap) and remainder = 0, div_by_zero = 0.
REQ-023 Divisor = 0 SHALL yield quotient = all ones, remainder = original dividend, div_by_zero = 1, after the normal latency.
REQ-024 Operand inputs changing after the accept edge SHALL NOT affect the result.

Reset
REQ-025 reset SHALL force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-026 reset during RUN or FINISH SHALL abort the operation with no done pulse; reset has priority over start.

Structure
REQ-027 State encodings, WIDTH default and the iteration-count width SHALL reside in the shared FPU package/header.
REQ-028 One combinational sub-module, div_step, SHALL implement a single shift-compare-subtract iteration; the counter and state register remain in seq_divider32.

Verification
REQ-029 Unsigned 100 / 7 -> after 33 edges done=1, quotient=14, remainder=2, div_by_zero=0.
REQ-030 Signed -7 / 2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF); signed 7 / -2 -> quotient=-3, remainder=1.
REQ-031 Divisor 0, dividend 0x12345678 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, same latency.
REQ-032 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned same operands -> quotient=0, remainder=0x80000000.
REQ-033 start pulsed at cycle 10 of a busy operation -> ignored; start held in done cycle -> second operation accepted, its done 33 edges later.
REQ-034 reset asserted at RUN iteration 15 -> next cycle busy=0, done=0, all outputs 0; no done pulse follows.

Source files
------------

// File: rtl/seq_divider32_pkg.sv
// Purpose : shared constants for the sequential divider (width, counter width, FSM encodings).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package seq_divider32_pkg;

    // Default operand/result width; one quotient bit is produced per RUN cycle.
    localparam int DIV_WIDTH = 32;

    // Iteration counter width: counts 0 .. DIV_WIDTH-1.
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    // FSM encodings, kept as plain constants for compatibility with older blocks.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

endpackage

// File: rtl/seq_divider32_if.sv
// Purpose : request/result bundle between a divide requester (master) and seq_divider32 (slave).
// Latency : n/a (wiring only).
// Backpressure: none; the requester must only raise start while busy is low (start is ignored otherwise).
//   start, is_signed, dividend, divisor : master -> slave, sampled together on the accept edge
//   busy, done, quotient, remainder, div_by_zero : slave -> master, results held until next done
interface seq_divider32_if
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/seq_divider32_div_step.sv
// Purpose : one restoring-division iteration: shift {rem,quo} left, trial-subtract divisor, set quotient LSB.
// Latency : combinational.
// Backpressure: none.
//   rem_i/quo_i/dvsr_i : current partial remainder, quotient/dividend shift register, divisor magnitude
//   rem_o/quo_o        : values after this iteration
module div_step
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // The shifted remainder needs one extra bit: rem < divisor <= 2^WIDTH-1, so rem*2+1 < 2^(WIDTH+1).
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, dvsr_i};
        // No borrow out of the top bit means shifted >= divisor: keep the difference.
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider32.sv
// Purpose : sequential signed/unsigned restoring divider, one quotient bit per clock, MSB first.
// Latency : fixed; done pulses in the cycle after the (WIDTH+1)th edge following the accept edge.
// Backpressure: start is accepted only while idle (busy low, including the done cycle); ignored otherwise.
//   clk, reset (synchronous, active-high)
//   div_if (slave): start/is_signed/dividend/divisor in; busy/done/quotient/remainder/div_by_zero out
module seq_divider32
    import seq_divider32_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic           clk,
    input  logic           reset,
    seq_divider32_if.slave div_if
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] quo_q,       quo_d;
    logic [WIDTH-1:0] dvsr_q,      dvsr_d;
    logic             quo_neg_q,   quo_neg_d;
    logic             rem_neg_q,   rem_neg_d;
    logic             dvsr_zero_q, dvsr_zero_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q,       dbz_d;
    logic             done_q,      done_d;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             dividend_neg;
    logic             divisor_neg;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;
    logic             divisor_is_zero;

    // Operand magnitudes. The most-negative value maps onto itself, which read as
    // unsigned is exactly its magnitude.
    assign dividend_neg    = div_if.is_signed & div_if.dividend[WIDTH-1];
    assign divisor_neg     = div_if.is_signed & div_if.divisor[WIDTH-1];
    assign dividend_mag    = dividend_neg ? (~div_if.dividend + 1'b1) : div_if.dividend;
    assign divisor_mag     = divisor_neg  ? (~div_if.divisor  + 1'b1) : div_if.divisor;
    assign divisor_is_zero = (div_if.divisor == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_i  (rem_q),
        .quo_i  (quo_q),
        .dvsr_i (dvsr_q),
        .rem_o  (step_rem),
        .quo_o  (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvsr_d      = dvsr_q;
        quo_neg_d   = quo_neg_q;
        rem_neg_d   = rem_neg_q;
        dvsr_zero_d = dvsr_zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (div_if.start) begin
                    state_d     = ST_RUN;
                    cnt_d       = '0;
                    rem_d       = '0;
                    quo_d       = dividend_mag;
                    dvsr_d      = divisor_mag;
                    quo_neg_d   = (dividend_neg ^ divisor_neg) & ~divisor_is_zero;
                    rem_neg_d   = dividend_neg;
                    dvsr_zero_d = divisor_is_zero;
                end
            end

            ST_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FINISH;
                end
            end

            ST_FINISH: begin
                // A zero divisor needs no special casing here: every trial subtract
                // succeeds, so the quotient magnitude is all ones (never negated) and
                // the remainder ends as the dividend magnitude shifted through intact,
                // which the dividend-sign correction turns back into the original value.
                quotient_d  = quo_neg_q ? (~quo_q + 1'b1) : quo_q;
                remainder_d = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
                dbz_d       = dvsr_zero_q;
                done_d      = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            quo_neg_q   <= 1'b0;
            rem_neg_q   <= 1'b0;
            dvsr_zero_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvsr_q      <= dvsr_d;
            quo_neg_q   <= quo_neg_d;
            rem_neg_q   <= rem_neg_d;
            dvsr_zero_q <= dvsr_zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    // busy drops as FINISH hands back to IDLE, so it is already low in the done cycle.
    assign div_if.busy        = (state_q != ST_IDLE);
    assign div_if.done        = done_q;
    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Purpose : self-checking bench for seq_divider32: directed corner cases plus randomized operations.
// Latency : checks done arrives exactly WIDTH+1 edges after each accept edge.
// Backpressure: issues a new start as soon as busy is low; also probes start-while-busy and start-in-done-cycle.
module tb_seq_divider32;
    import seq_divider32_pkg::*;

    localparam int W   = DIV_WIDTH;
    localparam int LAT = W + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
        string        tag;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_divider32_if #(.WIDTH(W)) dif ();

    seq_divider32 #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .div_if (dif)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic. 64-bit signed division truncates toward
    // zero and gives the remainder the dividend's sign; the low bits wrap min/-1.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t   e;
        longint sa;
        longint sd;
        longint qq;
        longint rr;
        e.due = 0;
        e.tag = "";
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (s) begin
            sa    = $signed(a);
            sd    = $signed(b);
            qq    = sa / sd;
            rr    = sa % sd;
            e.q   = qq[W-1:0];
            e.r   = rr[W-1:0];
            e.dbz = 1'b0;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = 32'h8000_0000;
            3:       v = W'($urandom_range(1, 16));
            4:       v = -W'($urandom_range(1, 16));
            5:       v = W'($urandom) >> $urandom_range(0, 31);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Monitor: pops the oldest expected result on every done and compares.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && dif.done === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: done at cycle %0d, expected no operation outstanding", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk({e.tag, " quotient"},    dif.quotient,        e.q);
                    chk({e.tag, " remainder"},   dif.remainder,       e.r);
                    chk({e.tag, " div_by_zero"}, W'(dif.div_by_zero), W'(e.dbz));
                    chk({e.tag, " latency"},     W'(cyc),             W'(e.due));
                    chk({e.tag, " busy_in_done"}, W'(dif.busy),       W'(0));
                end
            end
        end
    end

    // All stimulus tasks run at posedge+1.
    task automatic wait_idle();
        int n = 0;
        while (dif.busy !== 1'b0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
        exp_t e;
        e     = model(a, b, s);
        e.due = cyc + LAT;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input string tag);
        wait_idle();
        dif.start     = 1'b1;
        dif.is_signed = s;
        dif.dividend  = a;
        dif.divisor   = b;
        @(posedge clk); #1;
        // Scramble operands after acceptance; the result must not change.
        dif.start     = 1'b0;
        dif.dividend  = W'($urandom);
        dif.divisor   = W'($urandom);
        dif.is_signed = 1'($urandom_range(0, 1));
        push_exp(a, b, s, tag);
        chk({tag, " busy_after_accept"}, W'(dif.busy), W'(1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dones;
        dif.start     = 1'b0;
        dif.is_signed = 1'b0;
        dif.dividend  = '0;
        dif.divisor   = '0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy",        W'(dif.busy),        W'(0));
        chk("reset done",        W'(dif.done),        W'(0));
        chk("reset quotient",    dif.quotient,        '0);
        chk("reset remainder",   dif.remainder,       '0);
        chk("reset div_by_zero", W'(dif.div_by_zero), W'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases.
        issue(32'd100,        32'd7,        1'b0, "u100/7");
        issue(-32'sd7,        32'd2,        1'b1, "s-7/2");
        issue(32'd7,          -32'sd2,      1'b1, "s7/-2");
        issue(32'h1234_5678,  32'd0,        1'b0, "u/0");
        issue(32'h1234_5678,  32'd0,        1'b1, "s/0");
        issue(-32'sd5,        32'd0,        1'b1, "s-5/0");
        issue(32'h8000_0000,  32'hFFFF_FFFF, 1'b1, "smin/-1");
        issue(32'h8000_0000,  32'hFFFF_FFFF, 1'b0, "umin/max");
        issue(32'd0,          32'd5,        1'b1, "s0/5");
        issue(32'hFFFF_FFFF,  32'd1,        1'b0, "umax/1");

        // Start pulsed mid-operation is ignored; start held into the done cycle is accepted.
        issue(32'd1000, 32'd3, 1'b0, "bb_first");
        repeat (9) begin @(posedge clk); #1; end
        dif.start    = 1'b1;
        dif.dividend = 32'd55;
        dif.divisor  = 32'd1;
        @(posedge clk); #1;
        dif.start    = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        dif.start     = 1'b1;
        dif.is_signed = 1'b1;
        dif.dividend  = -32'sd1000;
        dif.divisor   = 32'd7;
        n = 0;
        while (dif.done !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("bb done_seen", W'(dif.done), W'(1));
        @(posedge clk); #1;
        dif.start = 1'b0;
        push_exp(-32'sd1000, 32'd7, 1'b1, "bb_second");
        chk("bb busy_after_accept", W'(dif.busy), W'(1));

        // Randomized operations.
        for (int i = 0; i < 40; i++) begin
            issue(pick(), pick(), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        // Reset during RUN iteration 15 aborts with no done; reset beats start.
        issue(32'd100, 32'd7, 1'b0, "pre_abort");
        wait_idle();
        @(posedge clk); #1;
        dif.start     = 1'b1;
        dif.is_signed = 1'b0;
        dif.dividend  = 32'd999;
        dif.divisor   = 32'd4;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (15) begin @(posedge clk); #1; end
        reset     = 1'b1;
        dif.start = 1'b1;
        @(posedge clk); #1;
        reset     = 1'b0;
        dif.start = 1'b0;
        chk("abort busy",        W'(dif.busy),        W'(0));
        chk("abort done",        W'(dif.done),        W'(0));
        chk("abort quotient",    dif.quotient,        '0);
        chk("abort remainder",   dif.remainder,       '0);
        chk("abort div_by_zero", W'(dif.div_by_zero), W'(0));
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (dif.done === 1'b1) dones++;
        end
        chk("abort no_done", W'(dones), W'(0));

        // Post-abort operation still works.
        issue(32'd77, -32'sd10, 1'b1, "post_abort");

        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain outstanding", W'(sb.size()), W'(0));
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
